// File: rtl/cache_pkg.sv
// Shared parameters, address field positions and controller state encoding
// for the direct-mapped cache controller.
package cache_pkg;
  localparam int TAG_W  = 4;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 8;
  localparam int LINES  = 1 << IDX_W;
  localparam int ADDR_W = TAG_W + IDX_W;

  localparam int TAG_MSB = 7;
  localparam int TAG_LSB = 4;
  localparam int IDX_MSB = 3;
  localparam int IDX_LSB = 0;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESP
  } state_t;
endpackage

// File: rtl/cache_ctrl_decoder.sv
// Index to one-hot SRAM wordline decoder (inverse of the macro's encoder).
module cache_ctrl_decoder
  import cache_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [LINES-1:0] wl
);
  for (genvar i = 0; i < LINES; i++) begin : g_wl
    assign wl[i] = (idx == IDX_W'(i));
  end
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate cache controller driving a
// 16-line tag/data SRAM and a backing memory port.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sram_we,
  output logic [LINES-1:0]  sram_wl,
  output logic [TAG_W-1:0]  sram_tag_in,
  input  logic [TAG_W-1:0]  sram_tag_out,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fill_q;
  logic              hit_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic              hit;

  assign tag = addr_q[TAG_MSB:TAG_LSB];
  assign idx = addr_q[IDX_MSB:IDX_LSB];
  assign hit = (state_q == LOOKUP) && valid_q[idx] && (sram_tag_out == tag);

  cache_ctrl_decoder u_dec (.idx(idx), .wl(sram_wl));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      fill_q     <= '0;
      hit_q      <= 1'b0;
      valid_q    <= '0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      if (state_q == LOOKUP) begin
        hit_q <= hit;
        if (hit) begin
          if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
        end else if (miss_count != 8'hFF) begin
          miss_count <= miss_count + 8'd1;
        end
        // Read hits respond straight from the SRAM
        if (!we_q && hit) begin
          resp_rdata <= sram_data_out;
          resp_hit   <= 1'b1;
        end
      end
      if (state_q == MEM_RD && mem_ack) fill_q <= mem_rdata;
      if (state_q == FILL) begin
        valid_q[idx] <= 1'b1;
        resp_rdata   <= fill_q;
        resp_hit     <= 1'b0;
      end
      if (state_q == MEM_WR && mem_ack) begin
        resp_rdata <= '0;
        resp_hit   <= hit_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    sram_we      = 1'b0;
    sram_tag_in  = '0;
    sram_data_in = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (we_q) begin
          // Write-through: update the line only if present, memory always
          if (hit) begin
            sram_we      = 1'b1;
            sram_tag_in  = tag;
            sram_data_in = wdata_q;
          end
          state_d = MEM_WR;
        end else begin
          state_d = hit ? RESP : MEM_RD;
        end
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        sram_we      = 1'b1;
        sram_tag_in  = tag;
        sram_data_in = fill_q;
        state_d      = RESP;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
